// File: rtl/down_counter_divider_if.sv
// rtl/down_counter_divider_if.sv - control/status bundle for the loadable down-counter divider
interface down_counter_divider_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             mode;
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             busy;

  modport master (
    output load, load_val, en, mode,
    input  cnt, tc, busy
  );

  modport slave (
    input  load, load_val, en, mode,
    output cnt, tc, busy
  );
endinterface

// File: rtl/down_counter_divider.sv
// rtl/down_counter_divider.sv - loadable down-counter emitting a terminal-count tick every N enabled cycles
module down_counter_divider #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  down_counter_divider_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (bus.load) begin
      // A load always restarts; a zero ratio parks the counter without ever ticking.
      cnt_d    = bus.load_val;
      reload_d = bus.load_val;
      state_d  = (bus.load_val != '0) ? RUN : IDLE;
    end else if (state_q == RUN && bus.en) begin
      if (cnt_q > WIDTH'(1)) begin
        cnt_d = cnt_q - WIDTH'(1);
      end else if (cnt_q == WIDTH'(1)) begin
        tc_d = 1'b1;
        if (bus.mode) begin
          cnt_d = reload_q;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end else begin
        state_d = IDLE;
      end
    end

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.cnt  = cnt_q;
  assign bus.tc   = tc_q;
  assign bus.busy = busy_q;

endmodule
